// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer for a modular exponentiation datapath
module modexp_ctrl #(
  parameter int EXP_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [EXP_W-1:0] exponent,
  input  logic [5:0]       nbits,
  output logic             busy,
  output logic             acc_init,
  output logic             cnt_preset,
  output logic [5:0]       cnt_in,
  output logic             cnt_dec,
  input  logic             cnt_done,
  output logic             mul_start,
  output logic             mul_sel,
  input  logic             mul_done,
  output logic             done
);
  typedef enum logic [3:0] {IDLE, LOAD, SQ, WAIT_SQ, MUL, WAIT_MUL, NEXT, CHECK, FIN} state_t;
  localparam logic [5:0] W = 6'(EXP_W);
  state_t state, next;
  logic [EXP_W-1:0] exp_sr;
  logic [5:0] n, n_cap;
  logic take;
  assign take = state == IDLE && start;
  assign n_cap = nbits > W ? W : nbits;
  assign busy = state != IDLE;
  assign cnt_in = n;
  // next-state; mul_done only counts in the WAIT states, which never coincide with mul_start
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = start ? LOAD : IDLE;
      LOAD:     next = n == 6'd0 ? FIN : SQ;
      SQ:       next = WAIT_SQ;
      WAIT_SQ:  next = mul_done ? (exp_sr[EXP_W-1] ? MUL : NEXT) : WAIT_SQ;
      MUL:      next = WAIT_MUL;
      WAIT_MUL: next = mul_done ? NEXT : WAIT_MUL;
      NEXT:     next = CHECK;
      CHECK:    next = cnt_done ? FIN : SQ;
      FIN:      next = IDLE;
      default:  next = IDLE;
    endcase
  end
  // state, exponent shifter and registered pulses; datapath pulses are registered from the
  // next state so they line up with their state, done lands in the cycle after FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      exp_sr     <= '0;
      n          <= '0;
      acc_init   <= 1'b0;
      cnt_preset <= 1'b0;
      cnt_dec    <= 1'b0;
      mul_start  <= 1'b0;
      mul_sel    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= next;
      exp_sr     <= take ? exponent << (EXP_W - int'(n_cap)) : state == NEXT ? exp_sr << 1 : exp_sr;
      n          <= take ? n_cap : 6'd0;
      acc_init   <= next == LOAD;
      cnt_preset <= next == LOAD;
      cnt_dec    <= next == NEXT;
      mul_start  <= next == SQ || next == MUL;
      mul_sel    <= next == MUL ? 1'b1 : next == SQ ? 1'b0 : mul_sel;
      done       <= state == FIN;
    end
  end
endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: directed scenarios with multiplier and down-counter models
module tb_modexp_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stray = 1'b0;
  logic [31:0] exponent = '0;
  logic [5:0] nbits = '0, cnt_in, cnt;
  logic busy, acc_init, cnt_preset, cnt_dec, cnt_done, mul_start, mul_sel, mul_done, done;
  logic [1:0] md;
  int total = 0, bad = 0;
  int ms_n, dec_n, done_n, ai_n, pre_n, busy_bad, dbl, sel_bad, lat, k;
  logic [63:0] seq;
  logic [5:0] pre_val;
  logic [4:0] prev, cur;
  logic last_sel;

  always #5 clk = ~clk;

  modexp_ctrl #(.EXP_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .exponent(exponent), .nbits(nbits),
    .busy(busy), .acc_init(acc_init), .cnt_preset(cnt_preset), .cnt_in(cnt_in),
    .cnt_dec(cnt_dec), .cnt_done(cnt_done), .mul_start(mul_start), .mul_sel(mul_sel),
    .mul_done(mul_done), .done(done)
  );

  // multiplier answers 3 cycles after mul_start; down-counter loads and decrements
  always @(posedge clk) begin
    if (rst) begin
      md  <= 2'd0;
      cnt <= 6'd0;
    end else begin
      md  <= mul_start ? 2'd3 : (md != 2'd0 ? md - 2'd1 : 2'd0);
      cnt <= cnt_preset ? cnt_in : (cnt_dec && cnt != 6'd0 ? cnt - 6'd1 : cnt);
    end
  end
  assign mul_done = (md == 2'd1) | stray;
  assign cnt_done = cnt == 6'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    ms_n = 0; dec_n = 0; done_n = 0; ai_n = 0; pre_n = 0;
    busy_bad = 0; dbl = 0; sel_bad = 0; seq = '0; pre_val = '0; prev = '0; last_sel = 1'b0;
  endtask

  task automatic sample();
    cur = {acc_init, cnt_preset, cnt_dec, mul_start, done};
    if ((prev & cur) != 5'd0) dbl++;
    prev = cur;
    if (mul_start) begin
      ms_n++;
      seq = {seq[62:0], mul_sel};
      last_sel = mul_sel;
    end
    if (md == 2'd1 && mul_sel !== last_sel) sel_bad++;
    if (cnt_dec) dec_n++;
    if (done) done_n++;
    if (acc_init) ai_n++;
    if (cnt_preset) begin
      pre_n++;
      pre_val = cnt_in;
    end
  endtask

  task automatic run(input logic [31:0] e, input logic [5:0] nb, input bit inj, input int budget);
    clr();
    exponent = e;
    nbits = nb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (1) begin
      sample();
      if (done) break;
      if (!busy) busy_bad++;
      if (lat >= budget) break;
      if (inj) begin
        start = busy;
        stray = mul_start | cnt_dec;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    stray = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic report(input string t, input int ems, input logic [63:0] eseq, input int edec,
                        input int epre, input int elat);
    chk({t, ".mul_starts"}, 64'(ms_n), 64'(ems));
    chk({t, ".mul_sel_seq"}, seq, eseq);
    chk({t, ".cnt_dec"}, 64'(dec_n), 64'(edec));
    chk({t, ".cnt_in"}, 64'(pre_val), 64'(epre));
    chk({t, ".acc_init"}, 64'(ai_n), 64'd1);
    chk({t, ".cnt_preset"}, 64'(pre_n), 64'd1);
    chk({t, ".done_n"}, 64'(done_n), 64'd1);
    chk({t, ".latency"}, 64'(lat), 64'(elat));
    chk({t, ".busy_gap"}, 64'(busy_bad), 64'd0);
    chk({t, ".pulse_twice"}, 64'(dbl), 64'd0);
    chk({t, ".sel_unstable"}, 64'(sel_bad), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out", 64'({busy, acc_init, cnt_preset, cnt_dec, mul_start, mul_sel, done, cnt_in}), 64'd0);
    rst = 1'b0;
    run(32'hB, 6'd4, 1'b0, 200);
    report("exp_b", 7, 64'h25, 4, 4, 39);
    run(32'hFF, 6'd0, 1'b0, 50);
    report("nbits0", 0, 64'h0, 0, 0, 3);
    run(32'hFFFF_FFFF, 6'd40, 1'b0, 1000);
    report("all_ones", 64, 64'h5555_5555_5555_5555, 32, 32, 323);
    run(32'hB, 6'd4, 1'b1, 200);
    report("inject", 7, 64'h25, 4, 4, 39);
    clr();
    exponent = 32'hB;
    nbits = 6'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(mul_sel && !mul_start) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach_wait_mul", 64'(k < 100), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out", 64'({busy, acc_init, cnt_preset, cnt_dec, mul_start, mul_sel, done, cnt_in}), 64'd0);
    rst = 1'b0;
    run(32'h1, 6'd1, 1'b0, 100);
    report("after_abort", 2, 64'h1, 1, 1, 13);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
